redmule_mx_fp16_packer: RTL
===========================

# redmule_mx_fp16_packer

Downstream stage of the MX decoder. It collects the decoder's narrow FP16 output beats (NUM_LANES elements per beat) and assembles them into full-width FP16 words for the RedMulE operand buffers. It emits each word with a per-element strobe and a last flag. Partial words at tile end are flushed zero-padded. With a consumer that is always ready, the block runs at one input beat per cycle.

## Interface
Parameters:
- BITW, 16, width of one FP16 element
- NUM_LANES, 4, elements per input beat; must match the decoder's NUM_LANES
- OUT_W, 256, output word width; must be a multiple of NUM_LANES*BITW
- Derived: NUM_OUT_ELEMS = OUT_W/BITW (16); BEATS = OUT_W/(NUM_LANES*BITW) (4); CNT_W = max(1, $clog2(BEATS))

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- fp16_valid_i  in  1  input beat valid
- fp16_ready_o  out  1  input beat accepted when valid&ready
- fp16_data_i  in  NUM_LANES*BITW  lane l at [BITW*l +: BITW]
- fp16_last_i  in  1  beat is the final beat of a tile; forces a flush
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  OUT_W  assembled word; element e at [BITW*e +: BITW]
- out_strb_o  out  NUM_OUT_ELEMS  1 = element holds decoded data, 0 = zero pad
- out_last_o  out  1  word closes a tile

## Operation
- Beat counter cnt_q (0..BEATS-1) indexes the assembly register asm_q.
  - Accepted beat b writes lane l to element b*NUM_LANES+l of asm_q.
  - The same beat sets the matching NUM_LANES strobe bits.
- Word completes on an accepted beat when cnt_q==BEATS-1 or fp16_last_i=1.
- On completion:
  - The output register is loaded from asm_q merged with the current beat.
  - Unwritten elements are forced to 0 with strobe 0.
  - out_last_o is loaded with fp16_last_i.
  - cnt_q returns to 0 and asm_q and strobes clear. No stale data carries into the next word.
- If the beat does not complete the word, cnt_q increments.
- Output slot states:
  - EMPTY (out_valid_q=0) -> FULL on completion.
  - FULL -> EMPTY on out_ready_i with no completion that cycle.
  - FULL -> FULL (reloaded) when out_ready_i and a completion coincide.
- fp16_ready_o = ~rst_i & (~out_valid_q | out_ready_i).
  - This applies to every beat, not only completing beats, so the input stalls while a full word waits.
  - This creates a combinational path from out_ready_i to fp16_ready_o. It is intentional and documented for integration.
- fp16_last_i on beat 0 yields a word of NUM_LANES valid elements (strobe low NUM_LANES bits set).
- fp16_valid_i with ready low: inputs are held by the producer; the block captures nothing.
- Values pass through bit-exact; there is no arithmetic on data.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_strb_o=0, out_last_o=0, cnt_q=0, asm_q=0.
- fp16_ready_o=0 while rst_i=1 and 1 from the first cycle after reset.
- Latency: completing beat accepted at edge N -> out_valid_o=1 from edge N (visible cycle N+1).
- Handshake rules on both ports:
  - Transfer on valid&ready at a rising edge.
  - out_valid_o, once high, stays high with out_data_o, out_strb_o and out_last_o stable until accepted.
- Throughput with out_ready_i tied high: one beat per cycle, one word every BEATS cycles, no bubbles.
- Reset mid-word discards the partial word and any pending output word. No flush occurs.
- A single completing beat with BEATS=1 is legal; every beat is then a word.

## Structure
- Shared package redmule_mx_pkg holds:
  - FP16_W = 16
  - the typedef fp16_t = logic [15:0]
  - the BEATS/NUM_OUT_ELEMS derivation function
  - These are shared with the decoder.
- No sub-module: the counter, assembly register and output slot sit in one module (~150 lines).
- An elaboration-time assertion checks OUT_W % (NUM_LANES*BITW) == 0.

## Test plan
- Full block: 8 beats, lane values 0x3C00+element index, out_ready_i=1 -> two words back-to-back.
  - Word 0 elements 0..15 = 0x3C00..0x3C0F, strobe 0xFFFF, last 0.
  - Word 1 elements 16..31 = 0x3C10..0x3C1F, with last=1 on beat 7.
- Partial flush: 2 beats with last on beat 1 -> one word, elements 0..7 data, 8..15 = 0x0000, out_strb_o=0x00FF, out_last_o=1.
  - Next word starts at element 0 with a clean strobe.
- Backpressure: out_ready_i=0 for 5 cycles after word 0 completes.
  - fp16_ready_o=0 during the stall.
  - out_data_o remains stable.
  - No beat is lost or duplicated after release.
- Simultaneous drain/reload: output FULL, out_ready_i=1 in the same cycle the 4th beat arrives.
  - The new word loads with out_valid_o continuously high.
  - Word count is exact.
- Reset mid-word: rst_i pulsed after 2 beats.
  - All outputs return to 0 next cycle.
  - The next 4 beats form a word containing only post-reset data.
- Decoder chain: redmule_mx_decoder driven by golden MXFP8-E4M3 vectors feeds this block.
  - Each 32-element block yields two 256-bit words matching the expected FP16 list in element order.

Source files
------------

// File: rtl/redmule_mx_pkg.sv
// Shared MX decoder / packer definitions.
// Element width, FP16 type and word-geometry helpers.
package redmule_mx_pkg;

    localparam int unsigned FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    function automatic int unsigned calc_beats(
        input int unsigned out_w,
        input int unsigned lanes,
        input int unsigned bitw
    );
        return out_w / (lanes * bitw);
    endfunction

    function automatic int unsigned calc_out_elems(
        input int unsigned out_w,
        input int unsigned bitw
    );
        return out_w / bitw;
    endfunction

endpackage

// File: rtl/redmule_mx_fp16_packer.sv
// Packs narrow FP16 decoder beats into full-width operand words.
// Partial words at tile end are flushed with zero padding.
module redmule_mx_fp16_packer
    import redmule_mx_pkg::*;
#(
    parameter int unsigned BITW      = FP16_W,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned OUT_W     = 256,
    localparam int unsigned NUM_OUT_ELEMS = calc_out_elems(OUT_W, BITW)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      fp16_valid_i,
    output logic                      fp16_ready_o,
    input  logic [NUM_LANES*BITW-1:0] fp16_data_i,
    input  logic                      fp16_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [OUT_W-1:0]          out_data_o,
    output logic [NUM_OUT_ELEMS-1:0]  out_strb_o,
    output logic                      out_last_o
);

    localparam int unsigned BEAT_W = NUM_LANES * BITW;
    localparam int unsigned BEATS  = calc_beats(OUT_W, NUM_LANES, BITW);
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((OUT_W % BEAT_W) != 0) begin : g_bad_cfg
        $error("OUT_W must be a multiple of NUM_LANES*BITW");
    end

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]         asm_q, asm_d;
    logic [NUM_OUT_ELEMS-1:0] strb_q, strb_d;
    slot_e                    slot_q, slot_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic [NUM_OUT_ELEMS-1:0] out_strb_q, out_strb_d;
    logic                     out_last_q, out_last_d;

    logic [OUT_W-1:0]         merge_data;
    logic [NUM_OUT_ELEMS-1:0] merge_strb;
    logic                     in_ready;
    logic                     accept;
    logic                     complete;

    // Input stalls on every beat while a finished word is still waiting.
    assign in_ready = ~rst_i & ((slot_q == SLOT_EMPTY) | out_ready_i);
    assign accept   = fp16_valid_i & in_ready;
    assign complete = accept
                    & ((cnt_q == CNT_W'(BEATS - 1)) | fp16_last_i);

    always_comb begin
        merge_data = asm_q;
        merge_strb = strb_q;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                merge_data[b*BEAT_W +: BEAT_W]       = fp16_data_i;
                merge_strb[b*NUM_LANES +: NUM_LANES] = '1;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        strb_d     = strb_q;
        out_data_d = out_data_q;
        out_strb_d = out_strb_q;
        out_last_d = out_last_q;
        if (complete) begin
            cnt_d      = '0;
            asm_d      = '0;
            strb_d     = '0;
            out_data_d = merge_data;
            out_strb_d = merge_strb;
            out_last_d = fp16_last_i;
        end else if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            asm_d  = merge_data;
            strb_d = merge_strb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        unique case (slot_q)
            SLOT_EMPTY: if (complete) slot_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready_i && !complete) slot_d = SLOT_EMPTY;
            default:    slot_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        out_valid_o  = (slot_q == SLOT_FULL);
        fp16_ready_o = in_ready;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            strb_q     <= '0;
            out_data_q <= '0;
            out_strb_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            strb_q     <= strb_d;
            out_data_q <= out_data_d;
            out_strb_q <= out_strb_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_data_o = out_data_q;
    assign out_strb_o = out_strb_q;
    assign out_last_o = out_last_q;

endmodule
